// File: rtl/exc_commit.sv
// Exception collection and commit: carries flags down D/E/M, commits at M, sequences flush/redirect.
// Optional interrupt commit is enabled by defining EXC_COMMIT_INT_EN.
module exc_commit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_bd,
  input  logic        f_adel,
  input  logic        d_ri,
  input  logic        d_sys,
  input  logic        d_bp,
  input  logic        d_eret,
  input  logic        e_ov,
  input  logic        e_adel,
  input  logic        e_ades,
  input  logic [31:0] e_vaddr,
  input  logic        exl,
  input  logic [31:0] epc_value,
  input  logic        int_req,
  output logic [6:0]  exc_vec,
  output logic        exc_bd,
  output logic [31:0] epc_out,
  output logic [31:0] badvaddr_out,
  output logic        eret_out,
  output logic        int_taken,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  vec;
    logic [31:0] vaddr;
    logic        eret;
  } stage_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  stage_t      d_q, d_d, e_q, e_d, m_q, m_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic m_flagged;
  logic exc_commit_w;
  logic kill_w;
  logic int_commit;

  assign m_flagged    = |m_q.vec;
  assign exc_commit_w = (state_q == IDLE) & m_q.valid & ~exl & (m_flagged | m_q.eret);
  assign kill_w       = (state_q == IDLE) & m_q.valid & exl & m_flagged;

`ifdef EXC_COMMIT_INT_EN
  assign int_commit = (state_q == IDLE) & m_q.valid & int_req & ~m_flagged & ~m_q.eret;
`else
  logic unused_int_req;
  assign unused_int_req = int_req;
  assign int_commit     = 1'b0;
`endif

  // M-stage reporting to CP0 is purely combinational from the M record.
  assign exc_bd       = m_q.bd;
  assign epc_out      = m_q.bd ? (m_q.pc - 32'd4) : m_q.pc;
  assign badvaddr_out = m_q.vec[6] ? m_q.pc : m_q.vaddr;
  assign redirect_pc  = redirect_pc_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    d_d           = d_q;
    e_d           = e_q;
    m_d           = m_q;
    redirect_pc_d = redirect_pc_q;
    exc_vec       = 7'd0;
    eret_out      = 1'b0;
    int_taken     = 1'b0;
    flush         = 1'b0;
    redirect      = 1'b0;

    // Records only move in IDLE; during FLUSH/DRAIN they stay empty so late flags are dropped.
    if (state_q == IDLE && advance) begin
      d_d.valid = f_valid;
      d_d.pc    = f_pc;
      d_d.bd    = f_bd;
      d_d.vec   = {f_adel, 6'd0};
      d_d.vaddr = 32'd0;
      d_d.eret  = 1'b0;
      e_d       = d_q;
      e_d.vec   = d_q.vec | {1'b0, d_ri, 1'b0, d_sys, d_bp, 2'b00};
      e_d.eret  = d_q.eret | d_eret;
      m_d       = e_q;
      m_d.vec   = e_q.vec | {2'b00, e_ov, 2'b00, e_adel, e_ades};
      m_d.vaddr = e_vaddr;
    end else if (kill_w) begin
      m_d.valid = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (exc_commit_w || int_commit) begin
          state_d       = FLUSH;
          exc_vec       = exc_commit_w ? m_q.vec : 7'd0;
          eret_out      = exc_commit_w & ~m_flagged;
          int_taken     = int_commit;
          redirect_pc_d = (exc_commit_w & ~m_flagged) ? epc_value : EXC_VECTOR;
        end
      end
      FLUSH: begin
        flush     = 1'b1;
        redirect  = 1'b1;
        d_d.valid = 1'b0;
        e_d.valid = 1'b0;
        m_d.valid = 1'b0;
        cnt_d     = 4'(DRAIN_CYCLES - 1);
        state_d   = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      d_q           <= '0;
      e_q           <= '0;
      m_q           <= '0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      d_q           <= d_d;
      e_q           <= e_d;
      m_q           <= m_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit; interrupt steps follow EXC_COMMIT_INT_EN.
module tb_exc_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        advance;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_bd;
  logic        f_adel;
  logic        d_ri, d_sys, d_bp, d_eret;
  logic        e_ov, e_adel, e_ades;
  logic [31:0] e_vaddr;
  logic        exl;
  logic [31:0] epc_value;
  logic        int_req;
  logic [6:0]  exc_vec;
  logic        exc_bd;
  logic [31:0] epc_out;
  logic [31:0] badvaddr_out;
  logic        eret_out;
  logic        int_taken;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  exc_commit dut (
    .clk(clk), .rst(rst), .advance(advance),
    .f_valid(f_valid), .f_pc(f_pc), .f_bd(f_bd), .f_adel(f_adel),
    .d_ri(d_ri), .d_sys(d_sys), .d_bp(d_bp), .d_eret(d_eret),
    .e_ov(e_ov), .e_adel(e_adel), .e_ades(e_ades), .e_vaddr(e_vaddr),
    .exl(exl), .epc_value(epc_value), .int_req(int_req),
    .exc_vec(exc_vec), .exc_bd(exc_bd), .epc_out(epc_out), .badvaddr_out(badvaddr_out),
    .eret_out(eret_out), .int_taken(int_taken), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic bd, input logic adel);
    f_valid = v;
    f_pc    = pc;
    f_bd    = bd;
    f_adel  = adel;
  endtask

  task automatic clear_inputs();
    advance   = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    d_ri      = 1'b0;
    d_sys     = 1'b0;
    d_bp      = 1'b0;
    d_eret    = 1'b0;
    e_ov      = 1'b0;
    e_adel    = 1'b0;
    e_ades    = 1'b0;
    e_vaddr   = 32'd0;
    exl       = 1'b0;
    epc_value = 32'd0;
    int_req   = 1'b0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_exc_vec"}, {25'd0, exc_vec}, 32'd0);
    checkOutput({tag, "_exc_bd"}, {31'd0, exc_bd}, 32'd0);
    checkOutput({tag, "_epc"}, epc_out, 32'd0);
    checkOutput({tag, "_badvaddr"}, badvaddr_out, 32'd0);
    checkOutput({tag, "_eret"}, {31'd0, eret_out}, 32'd0);
    checkOutput({tag, "_int"}, {31'd0, int_taken}, 32'd0);
    checkOutput({tag, "_flush"}, {31'd0, flush}, 32'd0);
    checkOutput({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
    checkOutput({tag, "_redirect_pc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(2);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Overflow, no delay slot
    applyStimulus(1'b1, 32'hbfc00100, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    e_ov = 1'b1;
    tick();
    e_ov = 1'b0;
    #1;
    checkOutput("ov_vec", {25'd0, exc_vec}, 32'h10);
    checkOutput("ov_epc", epc_out, 32'hbfc00100);
    checkOutput("ov_flush_early", {31'd0, flush}, 32'd0);
    tick();
    #1;
    checkOutput("ov_vec_once", {25'd0, exc_vec}, 32'd0);
    checkOutput("ov_flush", {31'd0, flush}, 32'd1);
    checkOutput("ov_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("ov_redirect_pc", redirect_pc, 32'hbfc00380);
    tick();
    #1;
    checkOutput("ov_drain_flush", {31'd0, flush}, 32'd0);
    tick(2);

    // Misaligned PC in a delay slot
    applyStimulus(1'b1, 32'h00400006, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick(2);
    #1;
    checkOutput("adel_vec", {25'd0, exc_vec}, 32'h40);
    checkOutput("adel_bd", {31'd0, exc_bd}, 32'd1);
    checkOutput("adel_epc", epc_out, 32'h00400002);
    checkOutput("adel_badvaddr", badvaddr_out, 32'h00400006);
    tick(4);

    // Oldest first: ades in EX beats ri in ID
    applyStimulus(1'b1, 32'h00000200, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00000204, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    d_ri    = 1'b1;
    e_ades  = 1'b1;
    e_vaddr = 32'h00001001;
    tick();
    d_ri    = 1'b0;
    e_ades  = 1'b0;
    e_vaddr = 32'd0;
    #1;
    checkOutput("oldest_vec", {25'd0, exc_vec}, 32'h01);
    checkOutput("oldest_badvaddr", badvaddr_out, 32'h00001001);
    checkOutput("oldest_epc", epc_out, 32'h00000200);
    tick();
    #1;
    checkOutput("oldest_flush", {31'd0, flush}, 32'd1);
    checkOutput("oldest_vec_flush", {25'd0, exc_vec}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checkOutput("oldest_no_second", {25'd0, exc_vec}, 32'd0);
    end

    // ERET
    applyStimulus(1'b1, 32'h00000300, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    d_eret    = 1'b1;
    epc_value = 32'h80001234;
    tick();
    d_eret = 1'b0;
    tick();
    #1;
    checkOutput("eret_pulse", {31'd0, eret_out}, 32'd1);
    checkOutput("eret_vec", {25'd0, exc_vec}, 32'd0);
    tick();
    epc_value = 32'h0;
    #1;
    checkOutput("eret_pulse_end", {31'd0, eret_out}, 32'd0);
    checkOutput("eret_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("eret_redirect_pc", redirect_pc, 32'h80001234);
    tick(3);

    // Exception and eret on one record: exception wins
    applyStimulus(1'b1, 32'h00000380, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    d_eret = 1'b1;
    tick();
    d_eret = 1'b0;
    e_ov   = 1'b1;
    tick();
    e_ov      = 1'b0;
    epc_value = 32'h80001234;
    #1;
    checkOutput("both_vec", {25'd0, exc_vec}, 32'h10);
    checkOutput("both_eret", {31'd0, eret_out}, 32'd0);
    tick();
    #1;
    checkOutput("both_redirect_pc", redirect_pc, 32'hbfc00380);
    epc_value = 32'd0;
    tick(3);

    // Flagged record with EXL set is killed
    applyStimulus(1'b1, 32'h00000500, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    e_ov = 1'b1;
    tick();
    e_ov    = 1'b0;
    exl     = 1'b1;
    advance = 1'b0;
    #1;
    checkOutput("exl_vec", {25'd0, exc_vec}, 32'd0);
    tick();
    exl = 1'b0;
    #1;
    checkOutput("exl_killed_vec", {25'd0, exc_vec}, 32'd0);
    checkOutput("exl_no_flush", {31'd0, flush}, 32'd0);
    tick();
    advance = 1'b1;
    #1;
    checkOutput("exl_no_flush_late", {31'd0, flush}, 32'd0);
    tick();

    // Commit under stall, then syscall during DRAIN
    applyStimulus(1'b1, 32'h00000400, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    d_sys = 1'b1;
    tick();
    d_sys = 1'b0;
    tick();
    advance = 1'b0;
    #1;
    checkOutput("stall_vec", {25'd0, exc_vec}, 32'h08);
    tick();
    #1;
    checkOutput("stall_flush", {31'd0, flush}, 32'd1);
    tick();
    advance = 1'b1;
    applyStimulus(1'b1, 32'h00000480, 1'b0, 1'b0);
    d_sys = 1'b1;
    #1;
    checkOutput("drain_sys_0", {25'd0, exc_vec}, 32'd0);
    tick();
    #1;
    checkOutput("drain_sys_1", {25'd0, exc_vec}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    d_sys = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("drain_sys_after", {25'd0, exc_vec}, 32'd0);
      checkOutput("drain_flush_after", {31'd0, flush}, 32'd0);
      tick();
    end

    // rst during DRAIN aborts straight to IDLE
    applyStimulus(1'b1, 32'h00000600, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    d_bp = 1'b1;
    tick();
    d_bp = 1'b0;
    tick();
    #1;
    checkOutput("bp_vec", {25'd0, exc_vec}, 32'h04);
    tick();
    #1;
    checkOutput("bp_flush", {31'd0, flush}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_all_zero("rst_drain");
    applyStimulus(1'b1, 32'h00000700, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    e_adel  = 1'b1;
    e_vaddr = 32'h00000703;
    tick();
    e_adel  = 1'b0;
    e_vaddr = 32'd0;
    #1;
    checkOutput("post_rst_vec", {25'd0, exc_vec}, 32'h02);
    checkOutput("post_rst_badvaddr", badvaddr_out, 32'h00000703);
    tick(4);

    // Interrupt on a clean M instruction
    applyStimulus(1'b1, 32'h00000100, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick(2);
    int_req = 1'b1;
    #1;
    checkOutput("int_vec", {25'd0, exc_vec}, 32'd0);
    checkOutput("int_epc", epc_out, 32'h00000100);
`ifdef EXC_COMMIT_INT_EN
    checkOutput("int_taken", {31'd0, int_taken}, 32'd1);
    tick();
    int_req = 1'b0;
    #1;
    checkOutput("int_flush", {31'd0, flush}, 32'd1);
    checkOutput("int_redirect_pc", redirect_pc, 32'hbfc00380);
`else
    checkOutput("int_taken_off", {31'd0, int_taken}, 32'd0);
    tick();
    int_req = 1'b0;
    #1;
    checkOutput("int_flush_off", {31'd0, flush}, 32'd0);
`endif
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
